// File: rtl/gpu_tile_pkg.sv
// Shared types and constants for the GPU tile scanout slice.
package gpu_tile_pkg;

  localparam int unsigned TILES_PER_WORD = 4;
  localparam int unsigned TILE_ID_W      = 8;
  localparam int unsigned FIELD_W        = 8;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [TILE_ID_W-1:0] id;
    logic [FIELD_W-1:0]   col;
    logic [FIELD_W-1:0]   row;
    logic [FIELD_W-1:0]   line;
    logic                 last;
  } tile_entry_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/gpu_tile_wordbuf.sv
// Two-entry map-word FIFO; the head word is presented one tile byte at a time.
module gpu_tile_wordbuf
  import gpu_tile_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  logic [DATA_W-1:0]    i_push_data,
  input  logic                 i_pop_byte,
  output logic [TILE_ID_W-1:0] o_head_byte,
  output logic [1:0]           o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic [1:0]        r_idx;
  logic              w_pop_b;
  logic              w_pop_word;
  logic              w_push;
  logic [DATA_W-1:0] w_head;

  assign w_pop_b    = i_pop_byte && (r_count != 2'd0);
  assign w_pop_word = w_pop_b && (r_idx == 2'(TILES_PER_WORD - 1));
  assign w_push     = i_push && ((r_count != 2'd2) || w_pop_word);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_idx    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_idx    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop_b) r_idx <= r_idx + 2'd1;
      if (w_pop_word) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop_word})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign o_head_byte = w_head[{r_idx, 3'b000} +: TILE_ID_W];
  assign o_count     = r_count;

endmodule

// File: rtl/gpu_tile_scanout.sv
// Walks the block map line-major per row, re-reading each map row for every
// pixel line, and streams tile IDs with coordinates over valid/ready.
module gpu_tile_scanout
  import gpu_tile_pkg::*;
#(
  parameter int unsigned MAP_COLS = 16,
  parameter int unsigned MAP_ROWS = 12,
  parameter int unsigned TILE_PX  = 16,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        frame_start,
  output logic                        ram_rd_en,
  output logic [ADDR_W-1:0]           ram_rd_addr,
  input  logic [DATA_W-1:0]           ram_rd_data,
  output logic                        tile_valid,
  input  logic                        tile_ready,
  output logic [7:0]                  tile_id,
  output logic [$clog2(MAP_COLS)-1:0] tile_col,
  output logic [$clog2(MAP_ROWS)-1:0] tile_row,
  output logic [$clog2(TILE_PX)-1:0]  tile_line,
  output logic                        tile_last,
  output logic                        busy
);

  localparam int unsigned COL_W  = $clog2(MAP_COLS);
  localparam int unsigned ROW_W  = $clog2(MAP_ROWS);
  localparam int unsigned LINE_W = $clog2(TILE_PX);
  localparam int unsigned WPR    = MAP_COLS / TILES_PER_WORD;
  localparam int unsigned CW_W   = clog2_min1(WPR);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW_W-1:0]     r_rd_cw;
  logic [LINE_W-1:0]   r_rd_line;
  logic [ROW_W-1:0]    r_rd_row;
  logic [COL_W-1:0]    r_col;
  logic [LINE_W-1:0]   r_line;
  logic [ROW_W-1:0]    r_row;
  logic                r_inflight;
  logic [1:0]          w_count;
  logic [TILE_ID_W-1:0] w_head_byte;
  logic                w_rd_en;
  logic                w_hs;
  logic                w_valid;
  logic                w_rd_last;
  logic                w_out_last;
  tile_entry_t         w_entry;

  assign w_rd_last  = (r_rd_row == ROW_W'(MAP_ROWS - 1)) && (r_rd_line == LINE_W'(TILE_PX - 1))
                   && (r_rd_cw == CW_W'(WPR - 1));
  assign w_out_last = (r_row == ROW_W'(MAP_ROWS - 1)) && (r_line == LINE_W'(TILE_PX - 1))
                   && (r_col == COL_W'(MAP_COLS - 1));
  assign w_valid    = (w_count != 2'd0);
  // A restart flushes the buffer, so no handshake may complete in that cycle.
  assign w_hs       = w_valid && tile_ready && !frame_start;

  gpu_tile_wordbuf #(
    .DATA_W (DATA_W)
  ) u_wordbuf (
    .i_clk       (ACLK),
    .i_rst_n     (ARESETN),
    .i_flush     (frame_start),
    .i_push      (r_inflight),
    .i_push_data (ram_rd_data),
    .i_pop_byte  (w_hs),
    .o_head_byte (w_head_byte),
    .o_count     (w_count)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    if (frame_start) begin
      w_state_nxt = SCAN;
    end else begin
      case (r_state)
        SCAN: begin
          // Issue only if the slot is guaranteed free when the data lands.
          if ((2'd2 - w_count) > {1'b0, r_inflight}) begin
            w_rd_en = 1'b1;
            if (w_rd_last) w_state_nxt = DRAIN;
          end
        end
        DRAIN:   if (w_hs && w_out_last) w_state_nxt = IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN || frame_start) begin
      r_inflight <= 1'b0;
      r_rd_cw    <= '0;
      r_rd_line  <= '0;
      r_rd_row   <= '0;
      r_col      <= '0;
      r_line     <= '0;
      r_row      <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        if (r_rd_cw == CW_W'(WPR - 1)) begin
          r_rd_cw <= '0;
          if (r_rd_line == LINE_W'(TILE_PX - 1)) begin
            r_rd_line <= '0;
            r_rd_row  <= (r_rd_row == ROW_W'(MAP_ROWS - 1)) ? '0 : r_rd_row + 1'b1;
          end else begin
            r_rd_line <= r_rd_line + 1'b1;
          end
        end else begin
          r_rd_cw <= r_rd_cw + 1'b1;
        end
      end
      if (w_hs) begin
        if (r_col == COL_W'(MAP_COLS - 1)) begin
          r_col <= '0;
          if (r_line == LINE_W'(TILE_PX - 1)) begin
            r_line <= '0;
            r_row  <= (r_row == ROW_W'(MAP_ROWS - 1)) ? '0 : r_row + 1'b1;
          end else begin
            r_line <= r_line + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_entry                  = '0;
    w_entry.id               = w_head_byte;
    w_entry.col[COL_W-1:0]   = r_col;
    w_entry.row[ROW_W-1:0]   = r_row;
    w_entry.line[LINE_W-1:0] = r_line;
    w_entry.last             = w_valid && w_out_last;
  end

  assign ram_rd_en   = w_rd_en;
  assign ram_rd_addr = ADDR_W'(r_rd_row) * ADDR_W'(WPR) + ADDR_W'(r_rd_cw);
  assign tile_valid  = w_valid;
  assign tile_id     = w_entry.id;
  assign tile_col    = w_entry.col[COL_W-1:0];
  assign tile_row    = w_entry.row[ROW_W-1:0];
  assign tile_line   = w_entry.line[LINE_W-1:0];
  assign tile_last   = w_entry.last;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_gpu_tile_scanout.sv
// Directed bench for gpu_tile_scanout with a 1-cycle-latency map RAM model.
module tb_gpu_tile_scanout;

  localparam int ENTRIES = 3072;
  localparam int READS   = 768;
  localparam int TIMEOUT = 12000;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        frame_start = 1'b0;
  logic        ram_rd_en;
  logic [9:0]  ram_rd_addr;
  logic [31:0] ram_rd_data = '0;
  logic        tile_valid;
  logic        tile_ready = 1'b0;
  logic [7:0]  tile_id;
  logic [3:0]  tile_col;
  logic [3:0]  tile_row;
  logic [3:0]  tile_line;
  logic        tile_last;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int rd_total = 0;
  logic [9:0] addr_ring [8];

  gpu_tile_scanout #(
    .MAP_COLS (16),
    .MAP_ROWS (12),
    .TILE_PX  (16),
    .ADDR_W   (10),
    .DATA_W   (32)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .frame_start (frame_start),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .tile_valid  (tile_valid),
    .tile_ready  (tile_ready),
    .tile_id     (tile_id),
    .tile_col    (tile_col),
    .tile_row    (tile_row),
    .tile_line   (tile_line),
    .tile_last   (tile_last),
    .busy        (busy)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] map_word(input logic [9:0] a);
    int k;
    k = int'(a);
    return {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
  endfunction

  always @(posedge ACLK) begin
    if (ram_rd_en) begin
      ram_rd_data <= map_word(ram_rd_addr);
      addr_ring[rd_total % 8] <= ram_rd_addr;
      rd_total <= rd_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fields();
    return 32'({tile_id, tile_col, tile_row, tile_line, tile_last});
  endfunction

  function automatic logic [31:0] exp_fields(input int idx);
    int r, l, c;
    r = idx / 256;
    l = (idx / 16) % 16;
    c = idx % 16;
    return 32'({8'(r * 16 + c), 4'(c), 4'(r), 4'(l), (idx == ENTRIES - 1)});
  endfunction

  task automatic start_frame();
    frame_start = 1'b1;
    @(negedge ACLK);
    frame_start = 1'b0;
  endtask

  // mode 0: ready always high; mode 1: ready high one cycle in three.
  // abort_at >= 0 restarts the frame when that entry is pending.
  task automatic scan(input int mode, input int abort_at);
    int idx, cyc, base;
    logic rdy, stall;
    logic [31:0] prev;
    idx = 0; cyc = 0; stall = 1'b0; prev = '0;
    base = rd_total;
    chk("busy_rise", 32'(busy), 1);
    while (idx < ENTRIES && cyc < TIMEOUT) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      tile_ready = rdy;
      if (stall) begin
        chk("hold_valid", 32'(tile_valid), 1);
        chk("hold_fields", fields(), prev);
      end
      chk("max_buffered", 32'((rd_total - base) - idx / 4 <= 2), 1);
      if (tile_valid) begin
        if (idx == abort_at) begin
          frame_start = 1'b1;
          tile_ready = 1'b0;
          @(negedge ACLK);
          frame_start = 1'b0;
          chk("abort_valid_drop", 32'(tile_valid), 0);
          return;
        end
        chk("entry", fields(), exp_fields(idx));
        if (mode == 0) chk("entry_cycle", 32'(cyc), 32'(idx + 2));
        if (rdy) idx++;
      end
      stall = tile_valid && !rdy;
      prev = fields();
      @(negedge ACLK);
      cyc++;
    end
    chk("entries", 32'(idx), 32'(ENTRIES));
    chk("reads", 32'(rd_total - base), 32'(READS));
    chk("busy_fall", 32'(busy), 0);
    chk("valid_after_end", 32'(tile_valid), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    chk("rst_ctl", 32'({ram_rd_en, ram_rd_addr, tile_valid, busy, tile_last}), 0);
    chk("rst_fields", 32'({tile_id, tile_col, tile_row, tile_line}), 0);
    repeat (2) @(negedge ACLK);
    chk("idle_no_read", 32'(ram_rd_en), 0);

    tile_ready = 1'b1;
    start_frame();
    scan(0, -1);

    start_frame();
    scan(1, -1);

    tile_ready = 1'b0;
    start_frame();
    base = rd_total;
    repeat (50) @(negedge ACLK);
    chk("stall_reads", 32'(rd_total - base), 2);
    chk("stall_addr0", 32'(addr_ring[base % 8]), 0);
    chk("stall_addr1", 32'(addr_ring[(base + 1) % 8]), 1);
    chk("stall_valid", 32'(tile_valid), 1);
    chk("stall_id", 32'(tile_id), 0);
    chk("stall_busy", 32'(busy), 1);
    frame_start = 1'b1;
    @(negedge ACLK);
    frame_start = 1'b0;
    chk("restart_valid_drop", 32'(tile_valid), 0);
    scan(0, -1);

    tile_ready = 1'b1;
    start_frame();
    scan(0, 100);
    scan(0, -1);

    tile_ready = 1'b1;
    start_frame();
    repeat (40) @(negedge ACLK);
    chk("midframe_valid", 32'(tile_valid), 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    chk("mid_rst_ctl", 32'({ram_rd_en, ram_rd_addr, tile_valid, busy, tile_last}), 0);
    chk("mid_rst_fields", 32'({tile_id, tile_col, tile_row, tile_line}), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      chk("post_rst_quiet", 32'({tile_valid, ram_rd_en, busy}), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpu_tile_scanout.md
Name: gpu_tile_scanout

Overview:
- Sits directly downstream of the GPU block-map store that the S_BLOCK_AXI slave writes: 32-bit words, 4 tile IDs per word.
- Each frame, walks the map row by row and repeats each map row once per pixel line of a tile.
- Streams tile IDs with their coordinates over a valid/ready interface to the pixel/texture stage (texture base addresses come from S_TEXTURE_AXI).
- A 2-word buffer allows back-to-back output at 1 tile per cycle.

Parameters:
- MAP_COLS, 16, tiles per map row; must be a multiple of 4.
- MAP_ROWS, 12, tile rows per frame.
- TILE_PX, 16, pixel lines per tile; power of 2.
- ADDR_W, 10, block-map word address width.
- DATA_W, 32, map word width; fixed at 32 (4 bytes).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- frame_start  in  1  single-cycle pulse; starts (or restarts) a frame scan
- ram_rd_en  out  1  map read strobe
- ram_rd_addr  out  ADDR_W  map word address
- ram_rd_data  in  DATA_W  read data, valid exactly 1 cycle after ram_rd_en
- tile_valid  out  1  output entry valid
- tile_ready  in  1  downstream accepts
- tile_id  out  8  tile ID
- tile_col  out  clog2(MAP_COLS)  map column
- tile_row  out  clog2(MAP_ROWS)  map row
- tile_line  out  clog2(TILE_PX)  pixel line within tile
- tile_last  out  1  last entry of frame (row MAP_ROWS-1, line TILE_PX-1, col MAP_COLS-1)
- busy  out  1  frame in progress

Behaviour:
- Reset: ARESETN low at a rising edge clears everything. All outputs 0, state IDLE, buffer empty, counters 0.
- Addressing:
  - word_addr = row*(MAP_COLS/4) + col/4.
  - Byte lane = col%4; byte 0 (bits 7:0) is the lowest column.
- Scan order: line-major within a row, then row. For each row: line 0..TILE_PX-1; for each line: col 0..MAP_COLS-1.
- Re-reads: each map row is re-read from RAM for every line. No line cache.
- States and transitions:
  - IDLE -> SCAN on frame_start; busy rises the next cycle.
  - SCAN -> DRAIN when the last word read has been issued.
  - DRAIN -> IDLE when the tile_last entry is accepted (tile_valid & tile_ready); busy falls the cycle after.
- Read issue: in SCAN, ram_rd_en is asserted for 1 cycle when all of these hold:
  - free buffer slots > reads in flight (max 1 in flight);
  - words remain.
  - Data is captured into the buffer tail on the next edge.
- Read latency: first tile_valid appears 2 cycles after frame_start is sampled (issue, then capture).
- Output:
  - The head word supplies byte[idx]. idx advances on each handshake.
  - After byte 3 is accepted the head word is popped.
  - tile_valid stays high, with all fields stable, until accepted (AXI-style; never drops without a handshake).
- Throughput: with tile_ready held high, sustained 1 entry/cycle after the first word. The read of word n+1 overlaps emission of word n.
- Backpressure: with tile_ready low, at most 2 words are buffered. No further ram_rd_en until a slot frees.
- Simultaneous pop and capture in the same cycle: both happen; occupancy unchanged.
- frame_start in IDLE: starts a frame at row 0, line 0, col 0.
- frame_start while busy (abort/restart):
  - Flush buffer; discard any in-flight read data; tile_valid drops next cycle.
  - Restart at row 0, line 0, col 0.
  - The pending entry is not required to be accepted.
- Counter wrap: col wraps at MAP_COLS-1 -> 0 and increments line. line wraps at TILE_PX-1 -> 0 and increments row. Never index past MAP_ROWS-1.
- Entries per frame: MAP_ROWS*TILE_PX*MAP_COLS; default 3072. Reads per frame: 768.
- Reset mid-frame: immediate return to reset state; outputs 0 in the cycle after the reset edge.

Decomposition:
- Package gpu_tile_pkg holds:
  - constants TILES_PER_WORD=4 and TILE_ID_W=8;
  - state enum {IDLE, SCAN, DRAIN};
  - typedef tile_entry_t {id, col, row, line, last}.
- Sub-module gpu_tile_wordbuf: a 2-entry word FIFO with a byte-index output mux. Ports: push, pop_byte, head_byte, count, flush.

Test Plan:
- Map word k = {4k+3, 4k+2, 4k+1, 4k} (bytes), tile_ready=1, frame_start pulse -> 3072 entries. Row 0 line 0 emits IDs 0..15 in order; row 1 line 0 emits 16..31. tile_last high only on entry 3072. busy low 1 cycle later.
- Same setup, check cycle timing -> first tile_valid 2 cycles after frame_start. Entries 0..15 on 16 consecutive cycles (no bubbles).
- tile_ready toggled 1-of-3 cycles -> identical ordered sequence to the first test. Fields stable while valid & !ready. ram_rd_en count = 768. Never more than 2 words buffered.
- tile_ready held 0 for 50 cycles after start -> exactly 2 ram_rd_en pulses (addresses 0, 1). tile_valid held with id=0.
- frame_start reasserted at entry 100 -> tile_valid low next cycle. Stream restarts at row 0, line 0, col 0, id 0. Full 3072 entries follow.
- ARESETN low for 1 cycle mid-frame -> all outputs 0 the next cycle. No tile_valid until a new frame_start.
